// File: rtl/riscv_core_stage_act_ctrl.sv
// Pipeline activation controller: per-stage ACT/CLR from a ramp/run/drain/halt FSM
// with stall freezing, flush clears and a global ACT gate.
module riscv_core_stage_act_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int RAMP_STEP  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_act,
  input  logic [NUM_STAGES-1:0] i_stall,
  input  logic [NUM_STAGES-1:0] i_flush,
  input  logic                  i_halt_req,
  input  logic                  i_resume_req,
  output logic [NUM_STAGES-1:0] o_stage_act,
  output logic [NUM_STAGES-1:0] o_stage_clr,
  output logic                  o_ctrl_act,
  output logic                  o_halted,
  output logic [1:0]            o_state_dbg
);

  localparam int RW = $clog2(NUM_STAGES * RAMP_STEP + 1);
  localparam int DW = $clog2(NUM_STAGES);
  localparam logic [RW-1:0] RAMP_END   = RW'((NUM_STAGES - 1) * RAMP_STEP);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_RAMP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t                r_state;
  logic [RW-1:0]         r_ramp_cnt;
  logic [DW-1:0]         r_drain_cnt;

  logic [RW-1:0]         w_ramp_inc;
  logic                  w_stall_any;
  logic                  w_gate;
  logic [NUM_STAGES-1:0] w_base_en;
  logic [NUM_STAGES-1:0] w_frozen;
  logic [NUM_STAGES-1:0] w_bubble;
  logic [NUM_STAGES-1:0] w_flush_clr;

  assign w_ramp_inc  = r_ramp_cnt + RW'(1);
  assign w_stall_any = |i_stall;
  assign w_gate      = i_rst_n & i_act;

  // Drain finishes on the unstalled cycle that takes the counter to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_RAMP;
      r_ramp_cnt  <= '0;
      r_drain_cnt <= '0;
    end else if (i_act) begin
      case (r_state)
        ST_RAMP: begin
          r_ramp_cnt <= w_ramp_inc;
          if (w_ramp_inc >= RAMP_END) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (i_halt_req) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (!w_stall_any) begin
            if (r_drain_cnt <= DW'(1)) begin
              r_drain_cnt <= '0;
              r_state     <= ST_HALTED;
            end else begin
              r_drain_cnt <= r_drain_cnt - DW'(1);
            end
          end
        end
        ST_HALTED: begin
          if (i_resume_req) r_state <= ST_RUN;
        end
        default: r_state <= ST_RAMP;
      endcase
    end
  end

  always_comb begin
    w_base_en = '0;
    case (r_state)
      ST_RAMP: begin
        for (int i = 0; i < NUM_STAGES; i++)
          w_base_en[i] = (32'(r_ramp_cnt) >= 32'(i * RAMP_STEP));
      end
      ST_RUN:   w_base_en = '1;
      ST_DRAIN: begin
        w_base_en    = '1;
        w_base_en[0] = 1'b0;
      end
      default:  w_base_en = '0;
    endcase
  end

  // frozen[i]: some stage at or above i stalls; flush_clr[j]: some stage above j flushes.
  always_comb begin
    w_frozen    = '0;
    w_bubble    = '0;
    w_flush_clr = '0;
    w_frozen[NUM_STAGES-1] = i_stall[NUM_STAGES-1];
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      w_frozen[i]    = w_frozen[i+1] | i_stall[i];
      w_flush_clr[i] = w_flush_clr[i+1] | i_flush[i+1];
    end
    for (int i = 1; i < NUM_STAGES; i++)
      w_bubble[i] = i_stall[i-1] & ~w_frozen[i];
  end

  assign o_stage_clr = {NUM_STAGES{w_gate}} & w_base_en & (w_bubble | w_flush_clr);
  assign o_stage_act = {NUM_STAGES{w_gate}} & w_base_en & (~w_frozen | w_flush_clr);
  assign o_ctrl_act  = w_gate & (r_state != ST_HALTED);
  assign o_halted    = w_gate & (r_state == ST_HALTED);
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_riscv_core_stage_act_ctrl.sv
// Bench for riscv_core_stage_act_ctrl: directed scenarios plus randomized traffic
// checked against an integer-level behavioural model of the activation rules.
module tb_riscv_core_stage_act_ctrl;

  localparam int N    = 5;
  localparam int STEP = 2;
  localparam int M_RAMP = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         act = 1'b0;
  logic [N-1:0] stall = '0;
  logic [N-1:0] flush = '0;
  logic         halt = 1'b0;
  logic         resume = 1'b0;
  logic [N-1:0] o_stage_act, o_stage_clr;
  logic         o_ctrl_act, o_halted;
  logic [1:0]   o_state_dbg;

  int errors = 0;
  int checks = 0;
  int m_mode, m_ramp, m_drain;
  logic [N-1:0] exp_q[$];

  riscv_core_stage_act_ctrl #(.NUM_STAGES(N), .RAMP_STEP(STEP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_act(act), .i_stall(stall), .i_flush(flush),
    .i_halt_req(halt), .i_resume_req(resume),
    .o_stage_act(o_stage_act), .o_stage_clr(o_stage_clr),
    .o_ctrl_act(o_ctrl_act), .o_halted(o_halted), .o_state_dbg(o_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // behavioural model
  task automatic model_reset();
    m_mode = M_RAMP; m_ramp = 0; m_drain = 0;
  endtask

  function automatic bit model_base(input int i);
    case (m_mode)
      M_RAMP:  return m_ramp >= i * STEP;
      M_RUN:   return 1'b1;
      M_DRAIN: return i != 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [N-1:0] model_stage(input bit want_clr);
    logic [N-1:0] r;
    int k, m;
    r = '0; k = -1; m = -1;
    for (int i = 0; i < N; i++) begin
      if (stall[i]) k = i;
      if (flush[i]) m = i;
    end
    if (rst_n && act)
      for (int i = 0; i < N; i++) begin
        if (want_clr) r[i] = model_base(i) && ((k >= 0 && i == k + 1) || i < m);
        else          r[i] = model_base(i) && (i > k || i < m);
      end
    return r;
  endfunction

  // driver: advance one clock and update the model with the inputs seen at the edge
  task automatic tick();
    @(posedge clk);
    if (rst_n && act) begin
      case (m_mode)
        M_RAMP: begin
          m_ramp++;
          if (m_ramp >= (N - 1) * STEP) m_mode = M_RUN;
        end
        M_RUN: if (halt) begin m_mode = M_DRAIN; m_drain = N - 1; end
        M_DRAIN: if (stall == '0) begin
          m_drain--;
          if (m_drain == 0) m_mode = M_HALTED;
        end
        default: if (resume) m_mode = M_RUN;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    act = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      stall = N'($urandom_range(1, (1 << N) - 1));
      flush = N'($urandom_range(1, (1 << N) - 1));
      #1;
      checks++; if (o_stage_act !== '0) begin errors++; $display("FAIL reset_act: got %b expected 00000", o_stage_act); end
      checks++; if (o_stage_clr !== '0) begin errors++; $display("FAIL reset_clr: got %b expected 00000", o_stage_clr); end
      checks++; if (o_ctrl_act !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0", o_ctrl_act); end
      checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", o_halted); end
      tick();
    end
    stall = '0; flush = '0;
  endtask

  task automatic test_ramp();
    logic [N-1:0] tbl [9];
    logic [N-1:0] e;
    tbl = '{5'b00001, 5'b00001, 5'b00011, 5'b00011, 5'b00111,
            5'b00111, 5'b01111, 5'b01111, 5'b11111};
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    rst_n = 1'b1;
    halt  = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) halt = 1'b0;
      #1;
      e = exp_q.pop_front();
      checks++; if (o_stage_act !== e) begin errors++; $display("FAIL ramp_act c%0d: got %b expected %b", c, o_stage_act, e); end
      checks++; if (o_stage_clr !== '0) begin errors++; $display("FAIL ramp_clr c%0d: got %b expected 00000", c, o_stage_clr); end
      checks++; if (o_ctrl_act !== 1'b1) begin errors++; $display("FAIL ramp_ctrl c%0d: got %b expected 1", c, o_ctrl_act); end
      tick();
    end
    #1;
    checks++; if (o_stage_act !== 5'b11111) begin errors++; $display("FAIL run_after_ramp: got %b expected 11111", o_stage_act); end
  endtask

  task automatic test_stall();
    stall = 5'b00100; #1;
    checks++; if (o_stage_act !== 5'b11000) begin errors++; $display("FAIL stall_act: got %b expected 11000", o_stage_act); end
    checks++; if (o_stage_clr !== 5'b01000) begin errors++; $display("FAIL stall_clr: got %b expected 01000", o_stage_clr); end
    stall = '0; #1;
    checks++; if (o_stage_act !== 5'b11111) begin errors++; $display("FAIL unstall_act: got %b expected 11111", o_stage_act); end
    checks++; if (o_stage_clr !== 5'b00000) begin errors++; $display("FAIL unstall_clr: got %b expected 00000", o_stage_clr); end
    tick();
  endtask

  task automatic test_flush_override();
    stall = 5'b00010; flush = 5'b01000; #1;
    checks++; if (o_stage_clr !== 5'b00111) begin errors++; $display("FAIL flush_clr: got %b expected 00111", o_stage_clr); end
    checks++; if (o_stage_act !== 5'b11111) begin errors++; $display("FAIL flush_act: got %b expected 11111", o_stage_act); end
    stall = 5'b00100; flush = 5'b00100; #1;
    checks++; if (o_stage_act !== 5'b11011) begin errors++; $display("FAIL same_idx_act: got %b expected 11011", o_stage_act); end
    checks++; if (o_stage_clr !== 5'b01011) begin errors++; $display("FAIL same_idx_clr: got %b expected 01011", o_stage_clr); end
    stall = '0; flush = 5'b00001; #1;
    checks++; if (o_stage_clr !== 5'b00000) begin errors++; $display("FAIL flush0_clr: got %b expected 00000", o_stage_clr); end
    flush = '0;
    tick();
  endtask

  task automatic test_halt_drain(input int stalled, input int exp_len);
    int  n;
    bit  done;
    halt = 1'b1; #1;
    tick();
    halt = 1'b0;
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      stall = (n < stalled) ? 5'b00001 : 5'b00000;
      #1;
      if (o_halted) done = 1'b1;
      else begin
        checks++; if (o_stage_act !== 5'b11110) begin errors++; $display("FAIL drain_act c%0d: got %b expected 11110", n, o_stage_act); end
        n++;
        tick();
      end
    end
    stall = '0;
    checks++; if (n !== exp_len) begin errors++; $display("FAIL drain_len: got %0d expected %0d", n, exp_len); end
    checks++; if (o_stage_act !== '0) begin errors++; $display("FAIL halted_act: got %b expected 00000", o_stage_act); end
    checks++; if (o_ctrl_act !== 1'b0) begin errors++; $display("FAIL halted_ctrl: got %b expected 0", o_ctrl_act); end
    halt = 1'b1; tick(); halt = 1'b0; #1;
    checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_in_halted: got %b expected 1", o_halted); end
    resume = 1'b1; tick(); resume = 1'b0; #1;
    checks++; if (o_stage_act !== 5'b11111) begin errors++; $display("FAIL resume_act: got %b expected 11111", o_stage_act); end
    checks++; if (o_ctrl_act !== 1'b1) begin errors++; $display("FAIL resume_ctrl: got %b expected 1", o_ctrl_act); end
    checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL resume_halted: got %b expected 0", o_halted); end
    tick();
  endtask

  task automatic test_act_freeze();
    rst_n = 1'b0; model_reset();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    act = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({o_stage_act, o_stage_clr, o_ctrl_act, o_halted} !== '0)
        begin errors++; $display("FAIL act0_outputs c%0d: got %b/%b/%b/%b expected all 0", c, o_stage_act, o_stage_clr, o_ctrl_act, o_halted); end
      tick();
    end
    act = 1'b1; #1;
    checks++; if (o_stage_act !== 5'b00011) begin errors++; $display("FAIL act_return: got %b expected 00011", o_stage_act); end
    tick(); #1;
    checks++; if (o_stage_act !== 5'b00111) begin errors++; $display("FAIL ramp_resume: got %b expected 00111", o_stage_act); end
  endtask

  task automatic test_async_reset_drain();
    int n;
    n = 0;
    while (m_mode != M_RUN && n < 20) begin tick(); n++; end
    halt = 1'b1; tick(); halt = 1'b0;
    tick();
    #3 rst_n = 1'b0; model_reset();
    #1;
    checks++; if ({o_stage_act, o_stage_clr, o_ctrl_act, o_halted} !== '0)
      begin errors++; $display("FAIL async_rst: got %b/%b/%b/%b expected all 0", o_stage_act, o_stage_clr, o_ctrl_act, o_halted); end
    @(posedge clk); #1 rst_n = 1'b1; #1;
    checks++; if (o_stage_act !== 5'b00001) begin errors++; $display("FAIL rst_ramp_act: got %b expected 00001", o_stage_act); end
    checks++; if (o_ctrl_act !== 1'b1) begin errors++; $display("FAIL rst_ramp_ctrl: got %b expected 1", o_ctrl_act); end
    for (int c = 0; c < 8; c++) tick();
    #1;
    checks++; if (o_stage_act !== 5'b11111) begin errors++; $display("FAIL no_pending_halt: got %b expected 11111", o_stage_act); end
  endtask

  task automatic test_random();
    logic [N-1:0] ea, ec;
    for (int c = 0; c < 500; c++) begin
      act    = ($urandom_range(0, 9) != 0);
      stall  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
      flush  = ($urandom_range(0, 5) == 0) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
      halt   = ($urandom_range(0, 7) == 0);
      resume = ($urandom_range(0, 3) == 0);
      rst_n  = ($urandom_range(0, 149) != 0);
      if (!rst_n) model_reset();
      #1;
      ea = model_stage(1'b0);
      ec = model_stage(1'b1);
      checks++; if (o_stage_act !== ea) begin errors++; $display("FAIL rand_act c%0d: got %b expected %b", c, o_stage_act, ea); end
      checks++; if (o_stage_clr !== ec) begin errors++; $display("FAIL rand_clr c%0d: got %b expected %b", c, o_stage_clr, ec); end
      checks++; if (o_ctrl_act !== (rst_n && act && m_mode != M_HALTED))
        begin errors++; $display("FAIL rand_ctrl c%0d: got %b expected %b", c, o_ctrl_act, rst_n && act && m_mode != M_HALTED); end
      checks++; if (o_halted !== (rst_n && act && m_mode == M_HALTED))
        begin errors++; $display("FAIL rand_halted c%0d: got %b expected %b", c, o_halted, rst_n && act && m_mode == M_HALTED); end
      tick();
    end
    rst_n = 1'b1; act = 1'b1; stall = '0; flush = '0; halt = 1'b0; resume = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp();
    test_stall();
    test_flush_override();
    test_halt_drain(0, 4);
    test_halt_drain(1, 5);
    test_act_freeze();
    test_async_reset_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
